bin_to_bcd_seq: RTL and testbench

- Iterative shift-add-3 (double-dabble) converter from an unsigned binary value to four BCD digits.
- Its digit and valid outputs drive the 4-digit multiplexed 7-segment display stage directly.
- Digit 3 is the leftmost digit, digit 0 the rightmost.
- Adds a start/busy/done handshake, leading-zero blanking and overflow reporting, using the display's code 10 ("E") and blank code 15.

---
 rtl/bin_to_bcd_seq_if.sv | 29 ++
 rtl/bin_to_bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and digit bus between the binary-to-BCD converter and its users.
// The converter takes the slave side; the requester or the display takes the master side.
interface bin_to_bcd_seq_if #(
    parameter int BIN_WIDTH = 14
);
    logic                 start;
    logic                 clear;
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic                 overflow;
    logic [3:0]           bcd_data_0;
    logic [3:0]           bcd_data_1;
    logic [3:0]           bcd_data_2;
    logic [3:0]           bcd_data_3;

    modport master (
        output start, clear, bin_in,
        input  busy, done, valid, overflow,
        input  bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3
    );

    modport slave (
        input  start, clear, bin_in,
        output busy, done, valid, overflow,
        output bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per clock, then a final
// clock that loads the display digits with overflow "E" and optional leading-zero blanking.
module bin_to_bcd_seq #(
    parameter int          BIN_WIDTH = 14,
    parameter int unsigned MAX_VALUE = 9999,
    parameter bit          BLANK_LZ  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    bin_to_bcd_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} state_t;

    localparam logic [3:0]  CODE_E     = 4'd10;
    localparam logic [3:0]  CODE_BLANK = 4'd15;
    localparam logic [15:0] ALL_BLANK  = {4{CODE_BLANK}};

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]          bcd_q, bcd_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 ovf_pending_q, ovf_pending_d;
    logic [15:0]          digits_q, digits_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic [BIN_WIDTH+15:0] cat;

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Zero nibbles above the first nonzero one become blank; the ones digit always shows.
    function automatic logic [15:0] blank_lz(input logic [15:0] b);
        logic [15:0] r;
        logic        lead;
        r    = b;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = CODE_BLANK;
            else                                lead = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        ovf_pending_d = ovf_pending_q;
        digits_d      = digits_q;
        valid_d       = valid_q;
        overflow_d    = overflow_q;
        done_d        = 1'b0;
        cat           = '0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.clear) begin
                    shift_d       = bus.bin_in;
                    bcd_d         = '0;
                    ovf_pending_d = (32'(bus.bin_in) > MAX_VALUE);
                    cnt_d         = 5'(BIN_WIDTH);
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                cat     = {add3(bcd_q), shift_q} << 1;
                bcd_d   = cat[BIN_WIDTH+15:BIN_WIDTH];
                shift_d = cat[BIN_WIDTH-1:0];
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = FINAL;
            end
            FINAL: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
                if (ovf_pending_q) begin
                    digits_d   = {CODE_E, CODE_BLANK, CODE_BLANK, CODE_BLANK};
                    overflow_d = 1'b1;
                end else begin
                    digits_d   = BLANK_LZ ? blank_lz(bcd_q) : bcd_q;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides any result loaded this cycle but never stops a running conversion.
        if (bus.clear) begin
            valid_d    = 1'b0;
            overflow_d = 1'b0;
            digits_d   = ALL_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            digits_q      <= ALL_BLANK;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            ovf_pending_q <= ovf_pending_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.bcd_data_0 = digits_q[3:0];
    assign bus.bcd_data_1 = digits_q[7:4];
    assign bus.bcd_data_2 = digits_q[11:8];
    assign bus.bcd_data_3 = digits_q[15:12];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized bench for bin_to_bcd_seq: a blanking and a non-blanking instance run the
// same stimulus and are compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_WIDTH(14)) if_b ();
    bin_to_bcd_seq_if #(.BIN_WIDTH(14)) if_z ();

    bin_to_bcd_seq #(.BIN_WIDTH(14), .MAX_VALUE(9999), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    bin_to_bcd_seq #(.BIN_WIDTH(14), .MAX_VALUE(9999), .BLANK_LZ(1'b0)) dut_z (
        .clk(clk), .rst(rst), .bus(if_z.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, then display rules (E on overflow, blanking).
    function automatic logic [15:0] model_digits(input int v, input bit blank);
        int          d[4];
        logic [15:0] r;
        bit          lead;
        if (v > 9999) return 16'hAFFF;
        d[3] = v / 1000;
        d[2] = (v / 100) % 10;
        d[1] = (v / 10) % 10;
        d[0] = v % 10;
        lead = blank;
        r    = '0;
        for (int i = 3; i >= 0; i--) begin
            if (lead && i > 0 && d[i] == 0) r[4*i +: 4] = 4'hF;
            else begin
                lead        = 1'b0;
                r[4*i +: 4] = 4'(d[i]);
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] dig_b();
        return {if_b.bcd_data_3, if_b.bcd_data_2, if_b.bcd_data_1, if_b.bcd_data_0};
    endfunction

    function automatic logic [15:0] dig_z();
        return {if_z.bcd_data_3, if_z.bcd_data_2, if_z.bcd_data_1, if_z.bcd_data_0};
    endfunction

    task automatic drive(input bit s, input bit c, input int b);
        if_b.start  = s;
        if_z.start  = s;
        if_b.clear  = c;
        if_z.clear  = c;
        if_b.bin_in = 14'(b);
        if_z.bin_in = 14'(b);
    endtask

    task automatic chk_idle_blank(input string tag);
        chk({tag, "_busy"}, {if_b.busy, if_z.busy}, 2'b00);
        chk({tag, "_done"}, {if_b.done, if_z.done}, 2'b00);
        chk({tag, "_valid"}, {if_b.valid, if_z.valid}, 2'b00);
        chk({tag, "_ovf"}, {if_b.overflow, if_z.overflow}, 2'b00);
        chk({tag, "_dig_b"}, dig_b(), 16'hFFFF);
        chk({tag, "_dig_z"}, dig_z(), 16'hFFFF);
    endtask

    // mode 0: plain; 1: start with 1111 pulsed on edge 5; 2: clear pulsed on edge 3;
    // 3: clear held on the final edge.
    task automatic convert(input int v, input int mode);
        int    k;
        int    extra;
        bit    busy_ok;
        bit    got;
        bit    exp_ovf;
        string t;
        t       = $sformatf("v%0d_m%0d", v, mode);
        exp_ovf = (v > 9999);
        drive(1'b1, 1'b0, v);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, v);
        busy_ok = 1'b1;
        got     = 1'b0;
        k       = 0;
        while (!got && k < 40) begin
            if (!(if_b.busy && if_z.busy) || if_b.done || if_z.done) busy_ok = 1'b0;
            if (mode == 1 && k == 4) drive(1'b1, 1'b0, 1111);
            if (mode == 1 && k == 5) drive(1'b0, 1'b0, 1111);
            if (mode == 2 && k == 2) drive(1'b0, 1'b1, v);
            if (mode == 2 && k == 3) drive(1'b0, 1'b0, v);
            if (mode == 3 && k == 14) drive(1'b0, 1'b1, v);
            @(posedge clk); #1;
            k++;
            if (mode == 2 && k == 3) begin
                chk({t, "_midclr_valid"}, {if_b.valid, if_z.valid}, 2'b00);
                chk({t, "_midclr_busy"}, {if_b.busy, if_z.busy}, 2'b11);
                chk({t, "_midclr_dig"}, dig_b(), 16'hFFFF);
            end
            if (if_b.done) got = 1'b1;
        end
        drive(1'b0, 1'b0, v);
        chk({t, "_latency"}, k, 15);
        chk({t, "_busy_during"}, busy_ok, 1'b1);
        chk({t, "_done_z"}, if_z.done, 1'b1);
        chk({t, "_busy_end"}, {if_b.busy, if_z.busy}, 2'b00);
        if (mode == 3) begin
            chk({t, "_valid"}, {if_b.valid, if_z.valid}, 2'b00);
            chk({t, "_ovf"}, {if_b.overflow, if_z.overflow}, 2'b00);
            chk({t, "_dig_b"}, dig_b(), 16'hFFFF);
            chk({t, "_dig_z"}, dig_z(), 16'hFFFF);
        end else begin
            chk({t, "_valid"}, {if_b.valid, if_z.valid}, 2'b11);
            chk({t, "_ovf"}, {if_b.overflow, if_z.overflow}, {exp_ovf, exp_ovf});
            chk({t, "_dig_b"}, dig_b(), model_digits(v, 1'b1));
            chk({t, "_dig_z"}, dig_z(), model_digits(v, 1'b0));
        end
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (if_b.done || if_z.done || if_b.busy || if_z.busy) extra++;
        end
        chk({t, "_quiet_after"}, extra, 0);
    endtask

    initial begin
        int v;
        int saw_done;
        drive(1'b0, 1'b0, 0);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_blank("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_blank("post_reset");

        convert(1234, 0);
        convert(0, 0);
        convert(7, 0);
        convert(305, 0);
        convert(9999, 0);
        convert(10000, 0);

        drive(1'b0, 1'b1, 0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 0);
        chk_idle_blank("clear_idle");

        convert(16383, 0);

        drive(1'b1, 1'b1, 77);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 77);
        chk_idle_blank("clear_start");
        @(posedge clk); #1;
        chk("clear_start_busy2", {if_b.busy, if_z.busy}, 2'b00);

        convert(4321, 1);
        convert(2468, 2);
        convert(135, 3);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(10000, 16383));
                1:       v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 9999));
            endcase
            convert(v, 0);
        end

        convert(5555, 0);
        drive(1'b1, 1'b0, 5678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5678);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_idle_blank("abort");
        saw_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (if_b.done || if_z.done) saw_done++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (if_b.done || if_z.done || if_b.busy) saw_done++;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_valid", {if_b.valid, if_z.valid}, 2'b00);
        convert(42, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
